// File: rtl/pc_halt_monitor_if.sv
// Bundle of core-side signals feeding the run-completion monitor and the status it returns.
// The core/bench drives through master; the monitor consumes through slave.
interface pc_halt_monitor_if #(
    parameter int PC_WIDTH  = 32,
    parameter int NUM_HALT  = 4,
    parameter int CNT_WIDTH = 32,
    parameter int ID_BITS   = (NUM_HALT > 1) ? $clog2(NUM_HALT) : 1
);
    logic                         start;
    logic [PC_WIDTH-1:0]          pc;
    logic                         pc_valid;
    logic [NUM_HALT*PC_WIDTH-1:0] halt_addr;
    logic [NUM_HALT-1:0]          halt_en;
    logic [CNT_WIDTH-1:0]         timeout_cycles;

    logic                         busy;
    logic                         done;
    logic                         timed_out;
    logic [ID_BITS-1:0]           halt_id;
    logic [PC_WIDTH-1:0]          final_pc;
    logic [CNT_WIDTH-1:0]         cycle_count;
    logic [CNT_WIDTH-1:0]         inst_count;
    logic                         report;

    modport master (
        output start, pc, pc_valid, halt_addr, halt_en, timeout_cycles,
        input  busy, done, timed_out, halt_id, final_pc, cycle_count, inst_count, report
    );

    modport slave (
        input  start, pc, pc_valid, halt_addr, halt_en, timeout_cycles,
        output busy, done, timed_out, halt_id, final_pc, cycle_count, inst_count, report
    );
endinterface

// File: rtl/pc_halt_monitor.sv
// Run-completion monitor: counts cycles and retired instructions, stops on a halt-address
// match (lowest channel wins) or on a cycle timeout, and pulses report once on completion.
module pc_halt_monitor #(
    parameter int PC_WIDTH  = 32,
    parameter int NUM_HALT  = 4,
    parameter int CNT_WIDTH = 32,
    parameter int ID_BITS   = (NUM_HALT > 1) ? $clog2(NUM_HALT) : 1
) (
    input  logic              clock,
    input  logic              reset,
    pc_halt_monitor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_reg;
    logic [CNT_WIDTH-1:0] cycle_reg;
    logic [CNT_WIDTH-1:0] inst_reg;
    logic [PC_WIDTH-1:0]  final_pc_reg;
    logic [ID_BITS-1:0]   halt_id_reg;
    logic                 timed_out_reg;
    logic                 report_reg;

    logic [NUM_HALT-1:0]  hit;
    logic                 match_any;
    logic [ID_BITS-1:0]   match_id;
    logic [CNT_WIDTH-1:0] cycle_plus;
    logic [CNT_WIDTH-1:0] cycle_next;
    logic [CNT_WIDTH-1:0] inst_next;
    logic                 timeout_hit;

    generate
        for (genvar gi = 0; gi < NUM_HALT; gi++) begin : g_hit
            assign hit[gi] = bus.pc_valid && bus.halt_en[gi] &&
                             (bus.pc == bus.halt_addr[gi*PC_WIDTH +: PC_WIDTH]);
        end
    endgenerate

    // Scan from the top so the lowest matching channel is the one left standing.
    always_comb begin
        match_any = 1'b0;
        match_id  = '0;
        for (int i = NUM_HALT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_any = 1'b1;
                match_id  = ID_BITS'(i);
            end
        end
    end

    // cycle_plus is the unsaturated sum so a timeout lands on exactly timeout_cycles edges.
    assign cycle_plus  = cycle_reg + CNT_WIDTH'(1);
    assign cycle_next  = (&cycle_reg) ? cycle_reg : cycle_plus;
    assign inst_next   = (&inst_reg)  ? inst_reg  : inst_reg + CNT_WIDTH'(1);
    assign timeout_hit = (bus.timeout_cycles != '0) && (cycle_plus == bus.timeout_cycles);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cycle_reg     <= '0;
            inst_reg      <= '0;
            final_pc_reg  <= '0;
            halt_id_reg   <= '0;
            timed_out_reg <= 1'b0;
            report_reg    <= 1'b0;
        end else begin
            report_reg <= 1'b0;
            if (bus.start) begin
                state_reg     <= RUN;
                cycle_reg     <= '0;
                inst_reg      <= '0;
                final_pc_reg  <= '0;
                halt_id_reg   <= '0;
                timed_out_reg <= 1'b0;
            end else if (state_reg == RUN) begin
                cycle_reg <= cycle_next;
                if (bus.pc_valid) begin
                    inst_reg <= inst_next;
                end
                if (match_any) begin
                    state_reg     <= DONE;
                    halt_id_reg   <= match_id;
                    final_pc_reg  <= bus.pc;
                    timed_out_reg <= 1'b0;
                    report_reg    <= 1'b1;
                end else if (timeout_hit) begin
                    state_reg     <= DONE;
                    halt_id_reg   <= '0;
                    final_pc_reg  <= '0;
                    timed_out_reg <= 1'b1;
                    report_reg    <= 1'b1;
                end
            end
        end
    end

    assign bus.busy        = (state_reg == RUN);
    assign bus.done        = (state_reg == DONE);
    assign bus.timed_out   = timed_out_reg;
    assign bus.halt_id     = halt_id_reg;
    assign bus.final_pc    = final_pc_reg;
    assign bus.cycle_count = cycle_reg;
    assign bus.inst_count  = inst_reg;
    assign bus.report      = report_reg;
endmodule

// File: tb/tb_pc_halt_monitor.sv
// Directed bench for pc_halt_monitor: a vector table for the halt/priority/restart runs
// plus hand-written sequences for reset, timeout, long runs and counter saturation.
module tb_pc_halt_monitor;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pc_halt_monitor_if #(.PC_WIDTH(32), .NUM_HALT(4), .CNT_WIDTH(32)) bus ();
    pc_halt_monitor_if #(.PC_WIDTH(32), .NUM_HALT(4), .CNT_WIDTH(4))  bus4 ();

    pc_halt_monitor #(.PC_WIDTH(32), .NUM_HALT(4), .CNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave)
    );
    pc_halt_monitor #(.PC_WIDTH(32), .NUM_HALT(4), .CNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4.slave)
    );

    typedef struct {
        logic        start;
        logic        pc_valid;
        logic [31:0] pc;
        logic [3:0]  halt_en;
        logic [31:0] tmo;
        logic        e_busy;
        logic        e_done;
        logic        e_to;
        logic [1:0]  e_id;
        logic [31:0] e_fpc;
        logic [31:0] e_cyc;
        logic [31:0] e_inst;
        logic        e_rep;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic st, logic pv, logic [31:0] pc, logic [3:0] en, logic [31:0] tmo,
                                logic eb, logic ed, logic et, logic [1:0] eid, logic [31:0] efp,
                                logic [31:0] ec, logic [31:0] ei, logic er);
        vec_t v;
        v.start = st; v.pc_valid = pv; v.pc = pc; v.halt_en = en; v.tmo = tmo;
        v.e_busy = eb; v.e_done = ed; v.e_to = et; v.e_id = eid; v.e_fpc = efp;
        v.e_cyc = ec; v.e_inst = ei; v.e_rep = er;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(string nm, logic eb, logic ed, logic et, logic [1:0] eid, logic [31:0] efp,
                         logic [31:0] ec, logic [31:0] ei, logic er);
        logic [102:0] act, exp;
        act = {bus.busy, bus.done, bus.timed_out, bus.halt_id, bus.final_pc,
               bus.cycle_count, bus.inst_count, bus.report};
        exp = {eb, ed, et, eid, efp, ec, ei, er};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got busy=%b done=%b to=%b id=%0d fpc=%h cyc=%0d inst=%0d rep=%b, want busy=%b done=%b to=%b id=%0d fpc=%h cyc=%0d inst=%0d rep=%b",
                     nm, bus.busy, bus.done, bus.timed_out, bus.halt_id, bus.final_pc, bus.cycle_count,
                     bus.inst_count, bus.report, eb, ed, et, eid, efp, ec, ei, er);
        end else begin
            $display("ok   %s: busy=%b done=%b to=%b id=%0d fpc=%h cyc=%0d inst=%0d rep=%b",
                     nm, bus.busy, bus.done, bus.timed_out, bus.halt_id, bus.final_pc,
                     bus.cycle_count, bus.inst_count, bus.report);
        end
    endtask

    task automatic check4(string nm, logic eb, logic [3:0] ec, logic [3:0] ei);
        n_vec++;
        if ({bus4.busy, bus4.done, bus4.cycle_count, bus4.inst_count} !== {eb, 1'b0, ec, ei}) begin
            n_bad++;
            $display("FAIL %s: got busy=%b done=%b cyc=%0d inst=%0d, want busy=%b done=0 cyc=%0d inst=%0d",
                     nm, bus4.busy, bus4.done, bus4.cycle_count, bus4.inst_count, eb, ec, ei);
        end else begin
            $display("ok   %s: busy=%b cyc=%0d inst=%0d", nm, bus4.busy, bus4.cycle_count, bus4.inst_count);
        end
    endtask

    initial begin
        bus.start = 0; bus.pc = '0; bus.pc_valid = 0; bus.halt_en = '0; bus.timeout_cycles = '0;
        bus.halt_addr = {32'h40, 32'h10, 32'h40, 32'hB0};   // ch3, ch2, ch1, ch0
        bus4.start = 0; bus4.pc = '0; bus4.pc_valid = 0; bus4.halt_en = '0; bus4.timeout_cycles = '0;
        bus4.halt_addr = '0;

        // Halt-match run: 9 retirements, two bubbles, match on RUN edge 12.
        vecs.push_back(mk(1, 0, 32'h0, 4'b0001, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 9; k++)
            vecs.push_back(mk(0, 1, 32'(4 * (k - 1)), 4'b0001, 0,  1, 0, 0, 0, 0, 32'(k), 32'(k), 0));
        vecs.push_back(mk(0, 0, 32'h0, 4'b0001, 0,  1, 0, 0, 0, 0, 10, 9, 0));
        vecs.push_back(mk(0, 0, 32'h0, 4'b0001, 0,  1, 0, 0, 0, 0, 11, 9, 0));
        vecs.push_back(mk(0, 1, 32'hB0, 4'b0001, 0, 0, 1, 0, 0, 32'hB0, 12, 10, 1));
        vecs.push_back(mk(0, 1, 32'hB0, 4'b0001, 0, 0, 1, 0, 0, 32'hB0, 12, 10, 0));
        vecs.push_back(mk(0, 1, 32'h44, 4'b0001, 0, 0, 1, 0, 0, 32'hB0, 12, 10, 0));
        // Priority: channels 1 and 3 both 0x40, timeout also due on edge 5.
        vecs.push_back(mk(1, 0, 32'h0, 4'b1010, 5,  1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 4; k++)
            vecs.push_back(mk(0, 1, 32'(32'h100 + 4 * k), 4'b1010, 5,  1, 0, 0, 0, 0, 32'(k), 32'(k), 0));
        vecs.push_back(mk(0, 1, 32'h40, 4'b1010, 5, 0, 1, 0, 1, 32'h40, 5, 5, 1));
        // Restart from DONE, then match on channel 2.
        vecs.push_back(mk(1, 1, 32'h10, 4'b0100, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h10, 4'b0100, 0, 0, 1, 0, 2, 32'h10, 1, 1, 1));

        // Reset held with pc_valid toggling.
        for (int k = 0; k < 4; k++) begin
            bus.pc_valid = k[0]; bus.pc = 32'hB0; bus.halt_en = 4'b0001;
            tick();
        end
        check("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 0;
        for (int k = 0; k < 20; k++) begin
            bus.pc_valid = k[0];
            tick();
        end
        check("idle_20", 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.start = vecs[i].start; bus.pc_valid = vecs[i].pc_valid; bus.pc = vecs[i].pc;
            bus.halt_en = vecs[i].halt_en; bus.timeout_cycles = vecs[i].tmo;
            tick();
            check($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done, vecs[i].e_to, vecs[i].e_id,
                  vecs[i].e_fpc, vecs[i].e_cyc, vecs[i].e_inst, vecs[i].e_rep);
        end

        // Timeout of 100 cycles, no halts enabled.
        bus.start = 1; bus.pc_valid = 0; bus.halt_en = 4'b0000; bus.timeout_cycles = 100;
        tick();
        bus.start = 0;
        for (int k = 1; k <= 99; k++) tick();
        check("tmo_99", 1, 0, 0, 0, 0, 99, 0, 0);
        tick();
        check("tmo_100", 0, 1, 1, 0, 0, 100, 0, 1);
        tick();
        check("tmo_hold", 0, 1, 1, 0, 0, 100, 0, 0);

        // Timeout disabled: run continues for 300 cycles.
        bus.start = 1; bus.timeout_cycles = 0;
        tick();
        bus.start = 0; bus.pc_valid = 1; bus.pc = 32'hB0;
        for (int k = 1; k <= 300; k++) tick();
        check("no_tmo_300", 1, 0, 0, 0, 0, 300, 300, 0);

        // Asynchronous reset mid-run.
        bus.start = 1; bus.halt_en = 4'b0000; bus.pc_valid = 1;
        tick();
        bus.start = 0;
        for (int k = 1; k <= 7; k++) tick();
        check("pre_reset", 1, 0, 0, 0, 0, 7, 7, 0);
        reset = 1;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 0;
        tick();
        check("after_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        // 4-bit counters saturate.
        bus4.start = 1;
        tick();
        check4("sat_start", 1, 4'd0, 4'd0);
        bus4.start = 0; bus4.pc_valid = 1;
        for (int k = 1; k <= 14; k++) tick();
        check4("sat_14", 1, 4'd14, 4'd14);
        for (int k = 15; k <= 40; k++) tick();
        check4("sat_40", 1, 4'd15, 4'd15);
        tick();
        check4("sat_hold", 1, 4'd15, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_halt_monitor.md
# pc_halt_monitor

Synthesizable run-completion monitor for the RISC-V core that counts clock cycles and retired instructions and detects program completion. Completion is signalled when the retiring PC matches any of NUM_HALT programmable halt addresses, or when a programmable cycle timeout expires. It sits beside the core, fed by the core's PC and a per-instruction valid strobe. It drives done/timeout status, the matched channel, final counter values and a one-cycle report pulse that the core's report input and benches consume.

## Interface
- PC_WIDTH, 32, width of PC and halt addresses
- NUM_HALT, 4, number of halt-address channels (≥1)
- CNT_WIDTH, 32, width of cycle/instruction counters and timeout
- ID_BITS, max(1, clog2(NUM_HALT)), width of halt_id
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a new run (level sampled each edge)
- pc  in  PC_WIDTH  PC of the instruction retiring this cycle
- pc_valid  in  1  pc holds a retiring instruction this cycle
- halt_addr  in  NUM_HALT*PC_WIDTH  channel i at bits [i*PC_WIDTH +: PC_WIDTH]
- halt_en  in  NUM_HALT  per-channel enable
- timeout_cycles  in  CNT_WIDTH  run limit in cycles; 0 disables timeout
- busy  out  1  state == RUN
- done  out  1  state == DONE
- timed_out  out  1  DONE was reached by timeout
- halt_id  out  ID_BITS  matched channel (valid when done && !timed_out)
- final_pc  out  PC_WIDTH  PC that matched; 0 on timeout
- cycle_count  out  CNT_WIDTH  cycles spent in RUN
- inst_count  out  CNT_WIDTH  pc_valid cycles counted in RUN
- report  out  1  one-cycle pulse on the first DONE cycle

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0.
- Any state, start=1 at an edge → RUN; cycle_count, inst_count, final_pc, halt_id, timed_out cleared; no match/timeout evaluated on that edge. start held high re-clears every edge (run stays at 0).
- RUN, start=0, per edge:
  - cycle_count += 1 (saturate at all-ones).
  - if pc_valid: inst_count += 1 (saturate).
  - match = pc_valid && halt_en[i] && pc == halt_addr[i]; the lowest matching index wins.
  - match → DONE; halt_id = i; final_pc = pc; timed_out = 0. The matching instruction is included in inst_count, and that edge's cycle increment is included.
  - else if timeout_cycles != 0 and cycle_count + 1 == timeout_cycles → DONE; timed_out = 1; final_pc = 0; halt_id = 0.
  - A match takes priority over a timeout on the same edge.
- DONE: counters frozen; outputs held until start or reset; pc_valid/pc ignored.
- IDLE: counters hold (0 after reset); pc ignored.
- halt_en all 0 with timeout 0 → RUN continues indefinitely; counters saturate.
- halt_addr, halt_en and timeout_cycles are sampled live each cycle; changing them mid-run takes effect the next edge.

## Timing
- Single clock domain; all outputs registered; no combinational input→output paths.
- start edge N → busy=1 after N. Match sampled at edge M → done=1, report=1 after M. report is low after M+1.
- cycle_count at DONE = number of RUN edges, including the terminating edge. Timeout T yields cycle_count == T exactly.
- reset asserted mid-run → immediately (asynchronously) IDLE, all outputs 0, report not issued.
- Restart from DONE: start edge → busy=1, done=0, timed_out=0, counters 0 on the same edge.

## Test plan
- Reset/idle: assert reset with pc_valid toggling → all outputs 0; after deassertion without start, counters stay 0 for 20 cycles.
- Halt match: halt_addr[0]=0xB0, halt_en=4'b0001, start 1 cycle, then 10 cycles pc_valid=1 with pc 0x00,0x04…; pc=0xB0 on RUN edge 12 → done=1, halt_id=0, final_pc=0xB0, cycle_count=12, inst_count=10, report high exactly 1 cycle.
- Priority and simultaneity: channels 1 and 3 both =0x40 and enabled, timeout_cycles=5, pc=0x40 valid on edge 5 → halt_id=1, timed_out=0, cycle_count=5.
- Timeout: halt_en=0, timeout_cycles=100 → done and timed_out at cycle_count=100, final_pc=0; timeout_cycles=0 with 300 cycles → busy stays 1.
- Saturation: CNT_WIDTH=4, no halts, timeout 0, 40 cycles with pc_valid=1 → cycle_count=inst_count=15, held.
- Reset mid-run and restart: reset at cycle 7 → outputs 0 asynchronously. Restart from DONE with start → counters 0, done=0, new run matches halt_addr[2]=0x10 → halt_id=2.
